// File: rtl/mips_pkg.sv
// mips_pkg: encodings shared by the instruction encoder and the control decoder.
// Holds the symbolic in_op enumeration, the primary opcode constants, the R-type
// funct constants and the encoder FSM state type.
package mips_pkg;

    // Symbolic operation selector carried on in_op; codes 12-15 are unsupported.
    typedef enum logic [3:0] {
        InAdd  = 4'd0,
        InSub  = 4'd1,
        InAnd  = 4'd2,
        InOr   = 4'd3,
        InSlt  = 4'd4,
        InAddi = 4'd5,
        InAndi = 4'd6,
        InLw   = 4'd7,
        InSw   = 4'd8,
        InBeq  = 4'd9,
        InBne  = 4'd10,
        InJ    = 4'd11
    } in_op_e;

    // Primary opcode field, instruction bits [31:26].
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct field, instruction bits [5:0].
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational packer from symbolic fields to a 32-bit MIPS word.
// Ports:
//   op          in   4   symbolic operation (mips_pkg::in_op_e)
//   rs, rt, rd  in   5   register fields
//   imm         in   26  immediate / branch offset (low 16) or jump target (all 26)
//   word        out  32  encoded instruction, 0 for unsupported ops
//   unsupported out  1   op is not one of the twelve defined codes
module instr_pack
    import mips_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        unsupported
);

    always_comb begin
        word        = 32'h0;
        unsupported = 1'b0;
        case (in_op_e'(op))
            InAdd:   word = {OP_RTYPE, rs, rt, rd, 5'h0, FUNCT_ADD};
            InSub:   word = {OP_RTYPE, rs, rt, rd, 5'h0, FUNCT_SUB};
            InAnd:   word = {OP_RTYPE, rs, rt, rd, 5'h0, FUNCT_AND};
            InOr:    word = {OP_RTYPE, rs, rt, rd, 5'h0, FUNCT_OR};
            InSlt:   word = {OP_RTYPE, rs, rt, rd, 5'h0, FUNCT_SLT};
            InAddi:  word = {OP_ADDI, rs, rt, imm[15:0]};
            InAndi:  word = {OP_ANDI, rs, rt, imm[15:0]};
            InLw:    word = {OP_LW, rs, rt, imm[15:0]};
            InSw:    word = {OP_SW, rs, rt, imm[15:0]};
            InBeq:   word = {OP_BEQ, rs, rt, imm[15:0]};
            InBne:   word = {OP_BNE, rs, rt, imm[15:0]};
            InJ:     word = {OP_J, imm};
            default: unsupported = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams symbolic instructions into instruction memory.
// Each accepted request is packed by instr_pack and written at consecutive word
// addresses starting from 0 after a start pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    pulse: (re)start a load at address 0
//   in_valid/in_ready        request handshake (in_ready is registered)
//   in_last                  marks the final request of the program
//   in_op, in_rs, in_rt, in_rd, in_imm   symbolic instruction fields
//   imem_we/addr/wdata       registered instruction-memory write port
//   count                    words written in the current load
//   full                     count == MAX_WORDS
//   done                     load finished (in_last written)
//   err                      sticky error, only live with INSTR_ENCODER_ERR_EN
// Configuration: define INSTR_ENCODER_ERR_EN to flag unsupported ops and
// out-of-range 16-bit immediates on err; otherwise err is tied 0.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    enc_state_e        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word;
    logic              unsupported;
    logic              xfer;

    instr_pack u_pack (
        .op          (in_op),
        .rs          (in_rs),
        .rt          (in_rt),
        .rd          (in_rd),
        .imm         (in_imm),
        .word        (word),
        .unsupported (unsupported)
    );

    // ready_q is only ever set in LOAD with room left, so it alone qualifies a transfer.
    assign xfer = in_valid && ready_q;

`ifdef INSTR_ENCODER_ERR_EN
    logic err_q, err_d;
    logic imm_wide;

    // Sign-extending I-types must fit their immediate in 16 bits; ANDI zero-extends.
    always_comb begin
        imm_wide = 1'b0;
        case (in_op_e'(in_op))
            InAddi, InLw, InSw, InBeq, InBne: imm_wide = (in_imm[25:16] != {10{in_imm[15]}});
            default:                          imm_wide = 1'b0;
        endcase
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef INSTR_ENCODER_ERR_EN
        err_d   = err_q;
`endif
        // Start from any state restarts the load; a write already latched still completes.
        if (start) begin
            state_d = StLoad;
            count_d = '0;
`ifdef INSTR_ENCODER_ERR_EN
            err_d   = 1'b0;
`endif
        end
        // count_d already reflects a coincident start, so that beat lands at address 0.
        if (xfer) begin
            we_d    = 1'b1;
            addr_d  = count_d[ADDR_W-1:0];
            wdata_d = unsupported ? 32'h0 : word;
            count_d = count_d + CNT_ONE;
`ifdef INSTR_ENCODER_ERR_EN
            err_d   = err_d | unsupported | imm_wide;
`endif
            if (in_last) begin
                state_d = StDone;
            end
        end
        ready_d = (state_d == StLoad) && (count_d != MAX_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
`ifdef INSTR_ENCODER_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef INSTR_ENCODER_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign in_ready   = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = (count_q == MAX_CNT);
    assign done       = (state_q == StDone);

`ifdef INSTR_ENCODER_ERR_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder and program loader for the single-cycle MIPS datapath. It accepts symbolic instructions over a valid/ready stream, packs each into a 32-bit MIPS word using the same opcode/funct assignments the control decoder consumes, and writes it into instruction memory at consecutive word addresses. It sits between the testbench or boot source and the instruction memory write port, and fills memory before the core is released.

## Interface
Parameters:
- ADDR_W, 8: instruction-memory word-address width.
- MAX_WORDS, 256: program capacity in words (≤ 2^ADDR_W).

Ports:
- clk  input  1: rising-edge clock; the block's only clock.
- rst  input  1: synchronous, active-high reset.
- start  input  1: one-cycle pulse; begins a load at word address 0.
- in_valid  input  1: request valid.
- in_ready  output  1: block can accept a request.
- in_last  input  1: qualifies the final request of the program.
- in_op  input  4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 ANDI, 7 LW, 8 SW, 9 BEQ, 10 BNE, 11 J; 12–15 unsupported.
- in_rs, in_rt, in_rd  input  5 each: register fields.
- in_imm  input  26: low 16 bits are the I-type immediate or branch word offset; all 26 bits are the J target.
- imem_we  output  1: instruction-memory write strobe.
- imem_addr  output  ADDR_W: word address.
- imem_wdata  output  32: encoded word.
- count  output  ADDR_W+1: words written in the current load.
- full  output  1: count == MAX_WORDS.
- done  output  1: load complete.
- err  output  1: sticky error (see Configuration).

## Operation
- The FSM has three states: IDLE, LOAD and DONE. Reset enters IDLE.
- IDLE → LOAD on start. In LOAD, in_ready = !full. After the write of a request accepted with in_last = 1, the FSM moves LOAD → DONE. In DONE, done = 1 and in_ready = 0. From DONE, start → LOAD.
- Entering LOAD from either state clears count to 0 and clears err.
- start while already in LOAD restarts the load: count returns to 0, and any write already in flight still completes.
- Handshake: a transfer occurs when in_valid && in_ready. Each transfer writes to imem_addr = the count value before increment, then count increments.
- Encoding:
  - R-type: {6'h00, rs, rt, rd, 5'h0, funct}, with funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
  - I-type: {op, rs, rt, imm[15:0]}, with op ADDI 0x08, ANDI 0x0C, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05.
  - J: {0x02, imm[25:0]}.
  - The unused field for each format is ignored.
- Full: when count reaches MAX_WORDS, in_ready drops and the FSM stays in LOAD. If in_last was never seen, the load is not complete.
- Reset at any time returns to IDLE and zeroes all outputs. Instruction-memory contents are not modified by reset.

## Timing
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, count 0, full 0, done 0, err 0.
- Latency is 1 cycle. A transfer at edge N produces imem_we/addr/wdata valid for exactly the cycle after edge N. count updates at the same edge.
- Throughput is one instruction per cycle. imem_we is never high for more than one cycle per transfer.
- done rises in the cycle after the in_last write.
- in_ready is a registered function of state and count; it has no combinational path from in_valid.

## Configuration
- INSTR_ENCODER_ERR_EN defined:
  - in_op 12–15 sets err (sticky), and the word written is 0x00000000.
  - ADDI/LW/SW/BEQ/BNE with in_imm[25:16] not equal to sign-extension of in_imm[15] set err; the word still encodes with the low 16 bits.
  - A transfer while full is impossible by construction.
- Undefined: err is tied 0, and unsupported ops silently write 0x00000000 (nop).

## Structure
- Shared package mips_pkg: the in_op enumeration, the opcode constants (OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_LW, OP_SW) and the funct constants. The control decoder shares these so encoder and decoder cannot diverge.
- One sub-module, instr_pack: a combinational encoder from in_* fields to the 32-bit word plus an unsupported flag. The top level holds the FSM, counter and output registers.

## Test plan
- start, then ADD rd=8 rs=9 rt=10 with in_last → imem_addr 0, wdata 0x012A4020, done high the next cycle, count 1.
- Back-to-back LW rt=8 rs=9 imm=4; SW rt=8 rs=9 imm=8; J imm=0x10 (last) → addresses 0, 1, 2 on consecutive cycles with data 0x8D280004, 0xAD280008, 0x08000010.
- BEQ rs=8 rt=9 imm=0x3FFFFFE (−2) → 0x1109FFFE, err 0.
- MAX_WORDS=4 with in_valid held and no in_last → 4 writes, full=1, in_ready=0, done=0, count 4.
- rst asserted mid-stream after 2 writes → next cycle all outputs 0 and state IDLE; a following start restarts at address 0.
- With INSTR_ENCODER_ERR_EN, in_op=13 → wdata 0x00000000, err=1 until the next start.
